// File: rtl/voxel_pkg.sv
// Shared types and helpers for the voxel fetch path: fetch state encoding,
// default grid sizing and the x/y/z to linear voxel index mapping.
package voxel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } fetch_state_e;

    localparam int COORD_WIDTH_DEF = 16;
    localparam int GX_BITS_DEF     = 5;
    localparam int GY_BITS_DEF     = 5;
    localparam int GZ_BITS_DEF     = 5;
    localparam int WORD_WIDTH_DEF  = 32;
    localparam int RAM_LATENCY_DEF = 2;

    // Packs {z, y, x} into a linear index; callers truncate to their own width.
    function automatic logic [63:0] voxel_index(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z,
        input int          gx,
        input int          gy,
        input int          gz
    );
        logic [63:0] xm;
        logic [63:0] ym;
        logic [63:0] zm;
        xm = {32'd0, x} & ((64'd1 << gx) - 64'd1);
        ym = {32'd0, y} & ((64'd1 << gy) - 64'd1);
        zm = {32'd0, z} & ((64'd1 << gz) - 64'd1);
        return (zm << (gx + gy)) | (ym << gx) | xm;
    endfunction

endpackage

// File: rtl/voxel_bounds_check.sv
// Combinational grid bounds check and linear index for one voxel coordinate.
// Kept standalone so a ray setup stage can reuse the same mapping.
module voxel_bounds_check
    import voxel_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int GX_BITS     = GX_BITS_DEF,
    parameter int GY_BITS     = GY_BITS_DEF,
    parameter int GZ_BITS     = GZ_BITS_DEF,
    parameter int IDX_W       = GX_BITS + GY_BITS + GZ_BITS
) (
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    input  logic [COORD_WIDTH-1:0] z,
    output logic                   out_of_bounds,
    output logic [IDX_W-1:0]       index
);

    // Any bit at or above the grid width marks the coordinate outside the grid,
    // which also catches a coordinate that wrapped below zero.
    assign out_of_bounds = (x[COORD_WIDTH-1:GX_BITS] != '0) ||
                           (y[COORD_WIDTH-1:GY_BITS] != '0) ||
                           (z[COORD_WIDTH-1:GZ_BITS] != '0);

    assign index = IDX_W'(voxel_index(32'(x), 32'(y), 32'(z), GX_BITS, GY_BITS, GZ_BITS));

endmodule

// File: rtl/voxel_fetch_unit.sv
// Answers per-voxel occupancy requests from the DDA step FSM using a bit-packed
// occupancy SRAM. Optional one-entry word cache enabled by VOXEL_FETCH_CACHE_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for req; accepts, bounds-checks and latches address
// ST_ISSUE | mem_en pulse; wait counter loaded with RAM_LATENCY-1
// ST_WAIT  | counting down; at zero mem_rdata is captured into solid_bit
// ST_RESP  | solid_valid pulse; never accepts, even if req is still high
module voxel_fetch_unit
    import voxel_pkg::*;
#(
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int GX_BITS     = GX_BITS_DEF,
    parameter int GY_BITS     = GY_BITS_DEF,
    parameter int GZ_BITS     = GZ_BITS_DEF,
    parameter int WORD_WIDTH  = WORD_WIDTH_DEF,
    parameter int RAM_LATENCY = RAM_LATENCY_DEF,
    parameter int IDX_W       = GX_BITS + GY_BITS + GZ_BITS,
    parameter int SEL_W       = $clog2(WORD_WIDTH),
    parameter int ADDR_W      = IDX_W - SEL_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req,
    input  logic [COORD_WIDTH-1:0] addr_x,
    input  logic [COORD_WIDTH-1:0] addr_y,
    input  logic [COORD_WIDTH-1:0] addr_z,
    input  logic                   invalidate,
    output logic                   solid_bit,
    output logic                   solid_valid,
    output logic                   out_of_bounds,
    output logic                   mem_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [WORD_WIDTH-1:0]  mem_rdata
);

    localparam int CNT_W = $clog2(RAM_LATENCY + 1);

    fetch_state_e     state;
    fetch_state_e     state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [SEL_W-1:0] sel_q;
    logic [IDX_W-1:0] index;
    logic [ADDR_W-1:0] word_addr;
    logic [SEL_W-1:0] word_sel;
    logic             accept;
    logic             cache_hit;
    logic             read_done;

    voxel_bounds_check #(
        .COORD_WIDTH (COORD_WIDTH),
        .GX_BITS     (GX_BITS),
        .GY_BITS     (GY_BITS),
        .GZ_BITS     (GZ_BITS),
        .IDX_W       (IDX_W)
    ) u_bounds (
        .x             (addr_x),
        .y             (addr_y),
        .z             (addr_z),
        .out_of_bounds (out_of_bounds),
        .index         (index)
    );

    assign word_addr = index[IDX_W-1:SEL_W];
    assign word_sel  = index[SEL_W-1:0];
    assign read_done = (state == ST_WAIT) && (wait_cnt == '0);

`ifdef VOXEL_FETCH_CACHE_EN
    logic                  cache_valid;
    logic [ADDR_W-1:0]     cache_tag;
    logic [WORD_WIDTH-1:0] cache_data;

    assign cache_hit = cache_valid && (cache_tag == word_addr);

    // An invalidate landing on the same cycle as a fill wins, so a job never
    // starts with a word fetched for the previous job.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (read_done) begin
            cache_valid <= ~invalidate;
            cache_tag   <= mem_addr;
            cache_data  <= mem_rdata;
        end else if (invalidate) begin
            cache_valid <= 1'b0;
        end
    end
`else
    logic unused_invalidate;

    assign unused_invalidate = invalidate;
    assign cache_hit         = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req && !solid_valid) begin
                    accept = 1'b1;
                    if (out_of_bounds || cache_hit) begin
                        state_nxt = ST_RESP;
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            solid_bit   <= 1'b0;
            solid_valid <= 1'b0;
            mem_en      <= 1'b0;
            mem_addr    <= '0;
            sel_q       <= '0;
            wait_cnt    <= '0;
        end else begin
            mem_en      <= (state_nxt == ST_ISSUE);
            solid_valid <= (state_nxt == ST_RESP);

            if (accept) begin
                if (out_of_bounds) begin
                    solid_bit <= 1'b0;
                end else if (cache_hit) begin
`ifdef VOXEL_FETCH_CACHE_EN
                    solid_bit <= cache_data[word_sel];
`endif
                end else begin
                    mem_addr <= word_addr;
                    sel_q    <= word_sel;
                end
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= CNT_W'(RAM_LATENCY - 1);
            end else if (state == ST_WAIT) begin
                if (wait_cnt != '0) begin
                    wait_cnt <= wait_cnt - 1'b1;
                end else begin
                    solid_bit <= mem_rdata[sel_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_voxel_fetch_unit.sv
// Directed testbench for voxel_fetch_unit with a latency-2 SRAM model.
// Cache scenarios are compiled when VOXEL_FETCH_CACHE_EN is defined.
module tb_voxel_fetch_unit;

    logic        clock;
    logic        reset;
    logic        req;
    logic [15:0] addr_x;
    logic [15:0] addr_y;
    logic [15:0] addr_z;
    logic        invalidate;
    logic        solid_bit;
    logic        solid_valid;
    logic        out_of_bounds;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] ram_s1;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cnt   = 0;
    int sv_cnt   = 0;
    int last_addr = -1;
    int lat;

    voxel_fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .addr_x        (addr_x),
        .addr_y        (addr_y),
        .addr_z        (addr_z),
        .invalidate    (invalidate),
        .solid_bit     (solid_bit),
        .solid_valid   (solid_valid),
        .out_of_bounds (out_of_bounds),
        .mem_en        (mem_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data appears two cycles after the mem_en cycle.
    always @(posedge clock) begin
        if (mem_en) ram_s1 <= mem[mem_addr];
        mem_rdata <= ram_s1;
    end

    always @(posedge clock) begin
        if (mem_en) begin
            en_cnt    = en_cnt + 1;
            last_addr = int'(mem_addr);
        end
        if (solid_valid) sv_cnt = sv_cnt + 1;
    end

    // Issues one request, returns cycles from acceptance to solid_valid
    // (-1 on timeout) and drops req in the cycle after the response.
    task automatic run_req(input int x, input int y, input int z, input bit inv, output int l);
        @(negedge clock);
        invalidate = inv;
        @(negedge clock);
        invalidate = 1'b0;
        req    = 1'b1;
        addr_x = 16'(x);
        addr_y = 16'(y);
        addr_z = 16'(z);
        l = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (solid_valid) begin
                l = i;
                break;
            end
        end
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL reset_solid_bit: got %b want 0", solid_bit); end
        n_checks++; if (solid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_solid_valid: got %b want 0", solid_valid); end
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_checks++; if (mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        n_checks++; if (out_of_bounds !== 1'b0) begin n_fail++; $display("FAIL reset_oob: got %b want 0", out_of_bounds); end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic_read();
        en_cnt = 0; sv_cnt = 0;
        run_req(3, 0, 0, 1'b1, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d want 4", lat); end
        n_checks++; if (en_cnt !== 1) begin n_fail++; $display("FAIL basic_mem_en_count: got %0d want 1", en_cnt); end
        n_checks++; if (last_addr !== 0) begin n_fail++; $display("FAIL basic_mem_addr: got %0d want 0", last_addr); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (solid_bit !== 1'b1) begin n_fail++; $display("FAIL basic_solid_hold%0d: got %b want 1", i, solid_bit); end
            @(negedge clock);
        end
    endtask

    task automatic test_index_map();
        en_cnt = 0;
        run_req(1, 2, 3, 1'b1, lat);
        n_checks++; if (last_addr !== 98) begin n_fail++; $display("FAIL map_mem_addr: got %0d want 98", last_addr); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL map_latency: got %0d want 4", lat); end
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL map_solid_bit: got %b want 0", solid_bit); end
        run_req(31, 31, 31, 1'b1, lat);
        n_checks++; if (last_addr !== 1023) begin n_fail++; $display("FAIL map_corner_addr: got %0d want 1023", last_addr); end
        n_checks++; if (solid_bit !== 1'b1) begin n_fail++; $display("FAIL map_corner_bit: got %b want 1", solid_bit); end
    endtask

    task automatic test_oob();
        run_req(3, 0, 0, 1'b1, lat);
        @(negedge clock);
        addr_x = 16'hFFFF; addr_y = 16'd0; addr_z = 16'd0;
        #1;
        n_checks++; if (out_of_bounds !== 1'b1) begin n_fail++; $display("FAIL oob_flag_x: got %b want 1", out_of_bounds); end
        addr_x = 16'd31; addr_y = 16'd31; addr_z = 16'd32;
        #1;
        n_checks++; if (out_of_bounds !== 1'b1) begin n_fail++; $display("FAIL oob_flag_z: got %b want 1", out_of_bounds); end
        addr_z = 16'd31;
        #1;
        n_checks++; if (out_of_bounds !== 1'b0) begin n_fail++; $display("FAIL oob_flag_edge: got %b want 0", out_of_bounds); end
        en_cnt = 0;
        run_req(16'hFFFF, 0, 0, 1'b1, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL oob_x_latency: got %0d want 1", lat); end
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL oob_x_solid: got %b want 0", solid_bit); end
        run_req(3, 0, 0, 1'b1, lat);
        en_cnt = 0;
        run_req(0, 32, 0, 1'b1, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL oob_y_latency: got %0d want 1", lat); end
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL oob_y_solid: got %b want 0", solid_bit); end
        n_checks++; if (en_cnt !== 0) begin n_fail++; $display("FAIL oob_mem_en: got %0d want 0", en_cnt); end
    endtask

    task automatic test_back_to_back();
        en_cnt = 0; sv_cnt = 0;
        run_req(0, 0, 0, 1'b1, lat);
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL b2b_first_bit: got %b want 0", solid_bit); end
        run_req(0, 1, 0, 1'b1, lat);
        n_checks++; if (solid_bit !== 1'b1) begin n_fail++; $display("FAIL b2b_second_bit: got %b want 1", solid_bit); end
        repeat (4) @(negedge clock);
        n_checks++; if (en_cnt !== 2) begin n_fail++; $display("FAIL b2b_mem_en_count: got %0d want 2", en_cnt); end
        n_checks++; if (sv_cnt !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 2", sv_cnt); end

        // req dropped and address moved while the read is in flight
        @(negedge clock); invalidate = 1'b1;
        @(negedge clock); invalidate = 1'b0;
        en_cnt = 0; sv_cnt = 0;
        req = 1'b1; addr_x = 16'd3; addr_y = 16'd0; addr_z = 16'd0;
        @(negedge clock);
        addr_y = 16'd3;
        @(negedge clock);
        req = 1'b0;
        repeat (8) @(negedge clock);
        n_checks++; if (sv_cnt !== 1) begin n_fail++; $display("FAIL drop_valid_count: got %0d want 1", sv_cnt); end
        n_checks++; if (en_cnt !== 1) begin n_fail++; $display("FAIL drop_mem_en_count: got %0d want 1", en_cnt); end
        n_checks++; if (last_addr !== 0) begin n_fail++; $display("FAIL drop_mem_addr: got %0d want 0", last_addr); end
        n_checks++; if (solid_bit !== 1'b1) begin n_fail++; $display("FAIL drop_solid_bit: got %b want 1", solid_bit); end
    endtask

    task automatic test_reset_mid_access();
        run_req(3, 0, 0, 1'b1, lat);
        @(negedge clock);
        req = 1'b1; addr_x = 16'd0; addr_y = 16'd5; addr_z = 16'd0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_solid_bit: got %b want 0", solid_bit); end
        n_checks++; if (mem_addr !== 10'd0) begin n_fail++; $display("FAIL rst_mid_mem_addr: got %0d want 0", mem_addr); end
        n_checks++; if (mem_en !== 1'b0 || solid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_strobes: got en=%b valid=%b want 0 0", mem_en, solid_valid); end
        req = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sv_cnt = 0;
        repeat (8) @(negedge clock);
        n_checks++; if (sv_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_valid: got %0d want 0", sv_cnt); end
        run_req(0, 1, 0, 1'b0, lat);
        n_checks++; if (last_addr !== 1) begin n_fail++; $display("FAIL rst_after_addr: got %0d want 1", last_addr); end
        n_checks++; if (solid_bit !== 1'b1) begin n_fail++; $display("FAIL rst_after_bit: got %b want 1", solid_bit); end
    endtask

`ifdef VOXEL_FETCH_CACHE_EN
    task automatic test_cache();
        mem[0] = 32'h0000_0028;
        en_cnt = 0;
        run_req(4, 0, 0, 1'b1, lat);
        n_checks++; if (lat !== 4 || en_cnt !== 1) begin n_fail++; $display("FAIL cache_miss: got lat=%0d en=%0d want 4 1", lat, en_cnt); end
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL cache_miss_bit: got %b want 0", solid_bit); end
        en_cnt = 0;
        run_req(5, 0, 0, 1'b0, lat);
        n_checks++; if (lat !== 1 || en_cnt !== 0) begin n_fail++; $display("FAIL cache_hit: got lat=%0d en=%0d want 1 0", lat, en_cnt); end
        n_checks++; if (solid_bit !== 1'b1) begin n_fail++; $display("FAIL cache_hit_bit: got %b want 1", solid_bit); end
        en_cnt = 0;
        run_req(6, 0, 0, 1'b1, lat);
        n_checks++; if (lat !== 4 || en_cnt !== 1) begin n_fail++; $display("FAIL cache_invalidate: got lat=%0d en=%0d want 4 1", lat, en_cnt); end
        n_checks++; if (solid_bit !== 1'b0) begin n_fail++; $display("FAIL cache_inv_bit: got %b want 0", solid_bit); end
        mem[0] = 32'h0000_0008;
    endtask
`else
    task automatic test_no_cache();
        en_cnt = 0;
        run_req(4, 0, 0, 1'b0, lat);
        run_req(3, 0, 0, 1'b0, lat);
        n_checks++; if (lat !== 4 || en_cnt !== 2) begin n_fail++; $display("FAIL nocache_same_word: got lat=%0d en=%0d want 4 2", lat, en_cnt); end
        n_checks++; if (solid_bit !== 1'b1) begin n_fail++; $display("FAIL nocache_bit: got %b want 1", solid_bit); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[0]    = 32'h0000_0008;
        mem[1]    = 32'h0000_0001;
        mem[98]   = 32'hFFFF_FFFD;
        mem[1023] = 32'h8000_0000;
        ram_s1     = 32'd0;
        reset      = 1'b1;
        req        = 1'b0;
        invalidate = 1'b0;
        addr_x     = 16'd0;
        addr_y     = 16'd0;
        addr_z     = 16'd0;

        test_reset();
        test_basic_read();
        test_index_map();
        test_oob();
        test_back_to_back();
        test_reset_mid_access();
`ifdef VOXEL_FETCH_CACHE_EN
        test_cache();
`else
        test_no_cache();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/voxel_fetch_unit.md
Name: voxel_fetch_unit

Overview:
Memory-side partner of the DDA step control FSM. It answers each per-voxel read request (level `req` plus x/y/z coordinates) with a registered solid bit and a one-cycle `solid_valid` pulse.
- Bounds checking is performed inside this block.
- The 3D coordinate is mapped to a bit-packed voxel SRAM word address.
- Out-of-bounds requests are returned without touching the SRAM.
- Sits between the step FSM and the single-port occupancy SRAM macro.

Parameters:
- COORD_WIDTH, 16, width of the incoming voxel coordinates.
- GX_BITS, 5, log2 of grid size in X (default grid 32).
- GY_BITS, 5, log2 of grid size in Y.
- GZ_BITS, 5, log2 of grid size in Z.
- WORD_WIDTH, 32, voxels packed per SRAM word; must be a power of 2.
- RAM_LATENCY, 2, cycles from the `mem_en` cycle to valid `mem_rdata`; must be ≥1.
- Derived: IDX_W = GX_BITS+GY_BITS+GZ_BITS; SEL_W = $clog2(WORD_WIDTH); ADDR_W = IDX_W-SEL_W (must be >0).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  1  level read request; held until `solid_valid`
- addr_x  in  COORD_WIDTH  voxel X
- addr_y  in  COORD_WIDTH  voxel Y
- addr_z  in  COORD_WIDTH  voxel Z
- invalidate  in  1  pulse at job start; clears the word cache
- solid_bit  out  1  registered occupancy of the last answered voxel
- solid_valid  out  1  one-cycle response strobe
- out_of_bounds  out  1  combinational bounds flag for the current addr_x/y/z
- mem_en  out  1  SRAM read enable, one-cycle pulse
- mem_addr  out  ADDR_W  SRAM word address
- mem_rdata  in  WORD_WIDTH  SRAM read data

Behaviour:
- Reset is asynchronous, active-high; clock is `clock`. Reset clears:
  - state → IDLE
  - `solid_bit`, `solid_valid`, `mem_en`, `mem_addr` → 0
  - wait counter → 0
  - cache valid → 0
- `out_of_bounds` = 1 when any coordinate bit at or above its G*_BITS position is set. Decrementing 0 yields 0xFFFF, which must flag OOB.
- Linear index = {z[GZ-1:0], y[GY-1:0], x[GX-1:0]}.
  - Word address = index[IDX_W-1:SEL_W].
  - Bit select = index[SEL_W-1:0], latched when the request is accepted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, request accepted when `req`=1 and `solid_valid`=0 in cycle t:
  - OOB → RESP with `solid_bit` ← 0, giving `solid_valid` in cycle t+1.
  - Otherwise → ISSUE, latching `mem_addr` and the bit select.
- ISSUE: `mem_en`=1 for exactly one cycle (t+1); counter ← RAM_LATENCY-1; → WAIT.
- WAIT: counter decrements each cycle. At 0, `mem_rdata` is valid: capture `mem_rdata[sel]` into `solid_bit` and → RESP.
  - In-bounds latency: `solid_valid` in cycle t+2+RAM_LATENCY.
- RESP: `solid_valid`=1 for one cycle; → IDLE.
  - `req` is still high in this cycle and must not start a new access.
  - The first new acceptance is possible in the cycle after RESP.
- `solid_bit` holds its value until the next response is registered. The consumer samples it up to 2 cycles after `solid_valid`.
- `req` dropped mid-access: the access completes and `solid_valid` still pulses (consumer ignores it). The FSM never aborts an SRAM read.
- Address change while busy: ignored; only the accepted address is served.
- Reset mid-access: the outstanding read is discarded and no `solid_valid` is produced.
- `invalidate` has no effect on an in-flight access other than cache clearing.

Optional Feature:
Macro VOXEL_FETCH_CACHE_EN.
- Defined: one-entry word cache holding tag (word address), data (WORD_WIDTH) and valid.
  - Filled on every SRAM response.
  - In-bounds request whose word address equals the tag with valid=1: → RESP with `solid_bit` ← cached[sel]. `solid_valid` at t+1, no `mem_en`.
  - `invalidate` or reset clears valid. An `invalidate` that coincides with a fill leaves valid=0.
- Undefined: no cache registers; every in-bounds request goes to SRAM; the `invalidate` port is present but ignored.

Decomposition:
- Package `voxel_pkg`:
  - fetch state enum (IDLE/ISSUE/WAIT/RESP)
  - grid-size default localparams
  - function computing linear index from x/y/z
- Sub-module `voxel_bounds_check` (pure combinational OOB + index), reusable by a ray setup stage.

Test Plan:
All scenarios use default parameters (grid 32, WORD_WIDTH 32, RAM_LATENCY 2).
1. req (3,0,0) with SRAM word 0 = 0x0000_0008 → `mem_en` once with `mem_addr`=0; `solid_valid` 4 cycles after `req`; `solid_bit`=1, held ≥3 cycles.
2. req (1,2,3) → index 3137, `mem_addr`=98, select bit 1; word 98 = 0xFFFF_FFFD → `solid_bit`=0.
3. req (0xFFFF,0,0) and req (0,32,0) → `out_of_bounds`=1, no `mem_en`, `solid_valid` at t+1, `solid_bit`=0.
4. `req` held high through `solid_valid` and dropped one cycle later → exactly one `mem_en` and one `solid_valid` per request; `req` dropped during WAIT still yields one `solid_valid`.
5. Reset asserted during WAIT → all outputs 0 immediately; no `solid_valid` afterwards; a new req (0,1,0) reads `mem_addr`=1.
6. With VOXEL_FETCH_CACHE_EN:
   - (4,0,0) then (5,0,0) → second request answers at t+1 with no `mem_en`.
   - `invalidate` then (6,0,0) → SRAM access occurs.
